player_input_conditioner: RTL and testbench
===========================================

// Module: player_input_conditioner
// PURPOSE
//   Front-end stage between the raw board inputs and the bomberman game core. Synchronises and
//   debounces player A's five push-buttons and player B's Pmod JA command nibble, and turns held
//   inputs into single-cycle move/bomb command pulses with auto-repeat on movement.
//   The game core consumes only these pulses and never sees raw pins.
// PARAMETERS
//   DEBOUNCE_CYCLES  1_000_000   stable cycles before a debounced value changes (10 ms @ 100 MHz)
//   REPEAT_DELAY     30_000_000  cycles a direction is held before the first auto-repeat
//   REPEAT_PERIOD    15_000_000  cycles between subsequent auto-repeat pulses
//   All counters are sized internally with $clog2 of their limit; all parameters must be >= 2.
// PORTS
//   clk          in   1  system clock, single domain
//   rst          in   1  asynchronous reset, ACTIVE-LOW (0 = reset)
//   btnU/btnD/btnL/btnR  in  1 each  player A direction buttons, raw, active-high
//   btnS         in   1  player A bomb button, raw, active-high
//   JA           in   8  player B Pmod; JA[4]=1 pad connected, JA[7:5]=command, JA[3:0] ignored
//   a_move       out  1  player A move pulse (one cycle)
//   a_dir        out  2  player A direction, valid with a_move: 00 U, 01 D, 10 L, 11 R
//   a_bomb       out  1  player A bomb pulse (one cycle per press)
//   b_move       out  1  player B move pulse
//   b_dir        out  2  player B direction, same encoding
//   b_bomb       out  1  player B bomb pulse
// BEHAVIOUR
//   Reset: rst=0 asynchronously clears all sync flops, debounced values, counters, FSMs to IDLE;
//     all outputs 0. Outputs are registered; a_dir/b_dir hold last value, 00 after reset.
//   Sync: every raw input passes a 2-flop synchroniser before any logic.
//   JA decode (after sync): JA[4]=0 -> NONE. Else JA[7:5]: 000 NONE, 001 U, 010 D, 011 L,
//     100 R, 101 BOMB, 110/111 NONE. Decoded 3-bit code is debounced as one unit.
//   Debounce: per channel (A: 5 bits; B: decoded code) counter increments each cycle
//     sync != debounced; clears whenever sync changes or equals debounced. Debounced value takes
//     the sync value when counter reaches DEBOUNCE_CYCLES. Any glitch shorter restarts the count.
//   Latency: raw edge -> 2 sync + DEBOUNCE_CYCLES -> debounced change; pulse registered 1 later.
//   Player A direction: priority U > D > L > R among debounced held buttons; none held = NONE.
//   Move FSM (one per player), states IDLE, HOLD, REPEAT:
//     IDLE: dir != NONE -> pulse move with dir, load REPEAT_DELAY, -> HOLD.
//     HOLD: count down; at 0 -> pulse, load REPEAT_PERIOD, -> REPEAT.
//     REPEAT: at 0 -> pulse, reload REPEAT_PERIOD, stay.
//     HOLD/REPEAT: dir -> NONE -> IDLE, no pulse; dir changes to another direction ->
//       immediate pulse with new dir, reload REPEAT_DELAY, -> HOLD.
//   Bomb: pulse on debounced rising edge only; no repeat while held. A bomb and move may pulse
//     in the same cycle (player A). Player B codes are exclusive, so BOMB -> direction change
//     gives a move pulse; direction -> BOMB gives a bomb pulse and move FSM -> IDLE.
//   Reset mid-hold: all pulses stop; after release of reset a still-held input is re-debounced
//     and produces a fresh first pulse.
// TESTING  (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=5)
//   rst=0 with btnS=1, JA=8'hB0 held -> all outputs 0 throughout; after rst=1 one a_bomb, one b_bomb.
//   btnS 0->1 held 40 cycles -> exactly one a_bomb, 7 cycles after first sampling edge (2+4+1).
//   btnU bounces 1,0,1,0 each 2 cycles then steady -> no pulse until steady 4 cycles; one a_move dir 00.
//   btnR held 30 cycles -> a_move/dir 11 at t0, t0+10, t0+15, t0+20, t0+25; release -> none.
//   JA 8'h10 -> 8'h30 -> 8'h70 while held -> b_move dir 00, then immediate b_move dir 10 after debounce.
//   JA=8'hB0 with JA[4]=0 (8'hA0) -> no b_bomb; btnU+btnL together -> a_dir 00 only.

Source files
------------

// File: rtl/player_input_conditioner.sv
// player_input_conditioner
//   Front end between the raw board inputs and the bomberman game core.
//   Synchronises and debounces player A's buttons and player B's Pmod command
//   nibble, then turns held inputs into single-cycle move/bomb pulses with
//   auto-repeat on movement.
// Ports (top)
//   clk                   system clock
//   rst                   asynchronous reset, active-low
//   btnU/btnD/btnL/btnR   player A direction buttons (raw, active-high)
//   btnS                  player A bomb button (raw, active-high)
//   JA[7:0]               player B Pmod: [4] pad present, [7:5] command, [3:0] unused
//   a_move/a_dir/a_bomb   player A pulses; dir 00 U, 01 D, 10 L, 11 R
//   b_move/b_dir/b_bomb   player B pulses, same encoding

// Debounces a vector as one unit. i_next is the synchroniser's first stage,
// used to see a change of i_sync one cycle ahead so a glitch clears the count.
module player_input_conditioner_debounce #(
  parameter int unsigned WIDTH           = 1,
  parameter int unsigned DEBOUNCE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_next,
  input  logic [WIDTH-1:0] i_sync,
  output logic [WIDTH-1:0] o_deb
);
  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_deb;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
      r_deb <= '0;
    end else if (i_sync == r_deb || i_next != i_sync) begin
      r_cnt <= '0;
    end else if (r_cnt == CW'(DEBOUNCE_CYCLES)) begin
      r_deb <= i_sync;
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_deb = r_deb;
endmodule

// Move pulse generator with auto-repeat. Counters load limit-1 so pulses are
// exactly REPEAT_DELAY / REPEAT_PERIOD cycles apart.
module player_input_conditioner_move #(
  parameter int unsigned REPEAT_DELAY  = 2,
  parameter int unsigned REPEAT_PERIOD = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_valid,
  input  logic [1:0] i_dir,
  output logic       o_move,
  output logic [1:0] o_dir
);
  localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned CW   = $clog2(RMAX);
  localparam logic [CW-1:0] LD_DELAY  = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] LD_PERIOD = CW'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_REPEAT} state_t;

  state_t        r_state, w_state_nx;
  logic [CW-1:0] r_cnt, w_cnt_nx;
  logic          w_pulse;
  logic          r_move;
  logic [1:0]    r_dir;

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_pulse    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_valid) begin
          w_pulse    = 1'b1;
          w_cnt_nx   = LD_DELAY;
          w_state_nx = S_HOLD;
        end
      end
      S_HOLD, S_REPEAT: begin
        if (!i_valid) begin
          w_state_nx = S_IDLE;
          w_cnt_nx   = '0;
        end else if (i_dir != r_dir) begin
          w_pulse    = 1'b1;
          w_cnt_nx   = LD_DELAY;
          w_state_nx = S_HOLD;
        end else if (r_cnt == '0) begin
          w_pulse    = 1'b1;
          w_cnt_nx   = LD_PERIOD;
          w_state_nx = S_REPEAT;
        end else begin
          w_cnt_nx = r_cnt - CW'(1);
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_move  <= 1'b0;
      r_dir   <= 2'b00;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_move  <= w_pulse;
      if (w_pulse) r_dir <= i_dir;
    end
  end

  assign o_move = r_move;
  assign o_dir  = r_dir;
endmodule

module player_input_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned REPEAT_DELAY    = 30_000_000,
  parameter int unsigned REPEAT_PERIOD   = 15_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btnU,
  input  logic       btnD,
  input  logic       btnL,
  input  logic       btnR,
  input  logic       btnS,
  input  logic [7:0] JA,
  output logic       a_move,
  output logic [1:0] a_dir,
  output logic       a_bomb,
  output logic       b_move,
  output logic [1:0] b_dir,
  output logic       b_bomb
);
  // Player A bit order: {U, D, L, R, S}
  logic [4:0] r_a_meta, r_a_sync;
  logic [3:0] r_ja_meta, r_ja_sync;
  logic       w_unused_ja;

  assign w_unused_ja = ^JA[3:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_a_meta  <= '0;
      r_a_sync  <= '0;
      r_ja_meta <= '0;
      r_ja_sync <= '0;
    end else begin
      r_a_meta  <= {btnU, btnD, btnL, btnR, btnS};
      r_a_sync  <= r_a_meta;
      r_ja_meta <= JA[7:4];
      r_ja_sync <= r_ja_meta;
    end
  end

  // Codes: 0 NONE, 1 U, 2 D, 3 L, 4 R, 5 BOMB -- equal to the raw command
  // value when the pad is present and the command is defined.
  function automatic logic [2:0] f_decode(input logic [3:0] i_ja);
    logic [2:0] v_cmd;
    v_cmd = i_ja[3:1];
    if (i_ja[0] && v_cmd >= 3'd1 && v_cmd <= 3'd5) return v_cmd;
    return 3'd0;
  endfunction

  logic [2:0] w_b_next_code, w_b_sync_code, w_b_deb;
  logic [4:0] w_a_deb;

  assign w_b_next_code = f_decode(r_ja_meta);
  assign w_b_sync_code = f_decode(r_ja_sync);

  player_input_conditioner_debounce #(
    .WIDTH          (5),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_deb_a (
    .clk   (clk),
    .rst   (rst),
    .i_next(r_a_meta),
    .i_sync(r_a_sync),
    .o_deb (w_a_deb)
  );

  player_input_conditioner_debounce #(
    .WIDTH          (3),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_deb_b (
    .clk   (clk),
    .rst   (rst),
    .i_next(w_b_next_code),
    .i_sync(w_b_sync_code),
    .o_deb (w_b_deb)
  );

  logic       w_a_valid, w_b_valid;
  logic [1:0] w_a_dir, w_b_dir;

  always_comb begin
    w_a_valid = |w_a_deb[4:1];
    if (w_a_deb[4])      w_a_dir = 2'b00;
    else if (w_a_deb[3]) w_a_dir = 2'b01;
    else if (w_a_deb[2]) w_a_dir = 2'b10;
    else                 w_a_dir = 2'b11;
  end

  always_comb begin
    w_b_valid = 1'b0;
    w_b_dir   = 2'b00;
    case (w_b_deb)
      3'd1: begin w_b_valid = 1'b1; w_b_dir = 2'b00; end
      3'd2: begin w_b_valid = 1'b1; w_b_dir = 2'b01; end
      3'd3: begin w_b_valid = 1'b1; w_b_dir = 2'b10; end
      3'd4: begin w_b_valid = 1'b1; w_b_dir = 2'b11; end
      default: ;
    endcase
  end

  player_input_conditioner_move #(
    .REPEAT_DELAY (REPEAT_DELAY),
    .REPEAT_PERIOD(REPEAT_PERIOD)
  ) u_move_a (
    .clk    (clk),
    .rst    (rst),
    .i_valid(w_a_valid),
    .i_dir  (w_a_dir),
    .o_move (a_move),
    .o_dir  (a_dir)
  );

  player_input_conditioner_move #(
    .REPEAT_DELAY (REPEAT_DELAY),
    .REPEAT_PERIOD(REPEAT_PERIOD)
  ) u_move_b (
    .clk    (clk),
    .rst    (rst),
    .i_valid(w_b_valid),
    .i_dir  (w_b_dir),
    .o_move (b_move),
    .o_dir  (b_dir)
  );

  // Bomb pulses on the debounced rising edge only.
  logic w_b_is_bomb;
  logic r_a_bomb_prev, r_b_bomb_prev, r_a_bomb, r_b_bomb;

  assign w_b_is_bomb = (w_b_deb == 3'd5);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_a_bomb_prev <= 1'b0;
      r_b_bomb_prev <= 1'b0;
      r_a_bomb      <= 1'b0;
      r_b_bomb      <= 1'b0;
    end else begin
      r_a_bomb_prev <= w_a_deb[0];
      r_b_bomb_prev <= w_b_is_bomb;
      r_a_bomb      <= w_a_deb[0] & ~r_a_bomb_prev;
      r_b_bomb      <= w_b_is_bomb & ~r_b_bomb_prev;
    end
  end

  assign a_bomb = r_a_bomb;
  assign b_bomb = r_b_bomb;
endmodule

// File: tb/tb_player_input_conditioner.sv
// Self-checking bench for player_input_conditioner with
// DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=5.
// Expected pulses are queued with the cycle they must appear on; any pulse
// the DUT produces is popped and compared. Stimulus changes just after a
// falling edge, so a change at cycle N is first sampled on posedge N+1 and
// its pulse is visible from cycle N+8 (2 sync + 4 debounce + 1 + 1).
module tb_player_input_conditioner;
  localparam int LAT = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       btnU = 1'b0, btnD = 1'b0, btnL = 1'b0, btnR = 1'b0, btnS = 1'b0;
  logic [7:0] JA = 8'h00;
  logic       a_move, a_bomb, b_move, b_bomb;
  logic [1:0] a_dir, b_dir;

  player_input_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (10),
    .REPEAT_PERIOD  (5)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .btnU  (btnU),
    .btnD  (btnD),
    .btnL  (btnL),
    .btnR  (btnR),
    .btnS  (btnS),
    .JA    (JA),
    .a_move(a_move),
    .a_dir (a_dir),
    .a_bomb(a_bomb),
    .b_move(b_move),
    .b_dir (b_dir),
    .b_bomb(b_bomb)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, wanted run to finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int         cyc;
    logic       am;
    logic [1:0] ad;
    logic       ab;
    logic       bm;
    logic [1:0] bd;
    logic       bb;
  } ev_t;

  typedef struct {
    logic [4:0] btn;  // {U, D, L, R, S}
    logic [7:0] ja;
    logic       am;
    logic [1:0] ad;
    logic       ab;
    logic       bm;
    logic [1:0] bd;
    logic       bb;
  } vec_t;

  ev_t  sb[$];
  int   errors = 0;
  int   checks = 0;
  vec_t vecs[18];

  task automatic expect_ev(input int at, input logic am, input logic [1:0] ad, input logic ab,
                           input logic bm, input logic [1:0] bd, input logic bb);
    ev_t e;
    e.cyc = at; e.am = am; e.ad = ad; e.ab = ab; e.bm = bm; e.bd = bd; e.bb = bb;
    sb.push_back(e);
  endtask

  task automatic sample();
    ev_t  e;
    logic ok;
    if (!rst) begin
      checks++;
      if ({a_move, a_dir, a_bomb, b_move, b_dir, b_bomb} != 8'b0) begin
        errors++;
        $display("FAIL reset_outputs cyc=%0d got=%b want=00000000", cyc,
                 {a_move, a_dir, a_bomb, b_move, b_dir, b_bomb});
      end
    end else if (a_move || a_bomb || b_move || b_bomb) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse cyc=%0d got am=%b ad=%b ab=%b bm=%b bd=%b bb=%b want none",
                 cyc, a_move, a_dir, a_bomb, b_move, b_dir, b_bomb);
      end else begin
        e  = sb.pop_front();
        ok = (e.cyc == cyc) && (a_move == e.am) && (!e.am || a_dir == e.ad) &&
             (a_bomb == e.ab) && (b_move == e.bm) && (!e.bm || b_dir == e.bd) &&
             (b_bomb == e.bb);
        if (!ok) begin
          errors++;
          $display("FAIL pulse got cyc=%0d am=%b ad=%b ab=%b bm=%b bd=%b bb=%b want cyc=%0d am=%b ad=%b ab=%b bm=%b bd=%b bb=%b",
                   cyc, a_move, a_dir, a_bomb, b_move, b_dir, b_bomb,
                   e.cyc, e.am, e.ad, e.ab, e.bm, e.bd, e.bb);
        end
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    sample();
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic drive(input logic [4:0] btn, input logic [7:0] ja);
    {btnU, btnD, btnL, btnR, btnS} = btn;
    JA = ja;
  endtask

  task automatic check_empty(input string name);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s missing_pulses got pending=%0d (first due cyc=%0d) want 0",
               name, sb.size(), sb[0].cyc);
      sb.delete();
    end
  endtask

  task automatic release_and_settle(input string name);
    drive(5'b0, 8'h00);
    ticks(14);
    check_empty(name);
  endtask

  initial begin
    int n;

    vecs[0]  = '{5'b10000, 8'h00, 1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0};
    vecs[1]  = '{5'b01000, 8'h00, 1'b1, 2'b01, 1'b0, 1'b0, 2'b00, 1'b0};
    vecs[2]  = '{5'b00100, 8'h00, 1'b1, 2'b10, 1'b0, 1'b0, 2'b00, 1'b0};
    vecs[3]  = '{5'b00010, 8'h00, 1'b1, 2'b11, 1'b0, 1'b0, 2'b00, 1'b0};
    vecs[4]  = '{5'b00001, 8'h00, 1'b0, 2'b00, 1'b1, 1'b0, 2'b00, 1'b0};
    vecs[5]  = '{5'b10100, 8'h00, 1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0};
    vecs[6]  = '{5'b01010, 8'h00, 1'b1, 2'b01, 1'b0, 1'b0, 2'b00, 1'b0};
    vecs[7]  = '{5'b00111, 8'h00, 1'b1, 2'b10, 1'b1, 1'b0, 2'b00, 1'b0};
    vecs[8]  = '{5'b00000, 8'h30, 1'b0, 2'b00, 1'b0, 1'b1, 2'b00, 1'b0};
    vecs[9]  = '{5'b00000, 8'h50, 1'b0, 2'b00, 1'b0, 1'b1, 2'b01, 1'b0};
    vecs[10] = '{5'b00000, 8'h70, 1'b0, 2'b00, 1'b0, 1'b1, 2'b10, 1'b0};
    vecs[11] = '{5'b00000, 8'h90, 1'b0, 2'b00, 1'b0, 1'b1, 2'b11, 1'b0};
    vecs[12] = '{5'b00000, 8'hB0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 1'b1};
    vecs[13] = '{5'b00000, 8'hA0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0};
    vecs[14] = '{5'b00000, 8'hD0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0};
    vecs[15] = '{5'b00000, 8'hF0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0};
    vecs[16] = '{5'b00000, 8'h3F, 1'b0, 2'b00, 1'b0, 1'b1, 2'b00, 1'b0};
    vecs[17] = '{5'b10000, 8'h90, 1'b1, 2'b00, 1'b0, 1'b1, 2'b11, 1'b0};

    // Reset held with bomb inputs active: silent, then one bomb each on release.
    drive(5'b00001, 8'hB0);
    ticks(10);
    rst = 1'b1;
    n = cyc;
    expect_ev(n + LAT, 1'b0, 2'b00, 1'b1, 1'b0, 2'b00, 1'b1);
    ticks(20);
    release_and_settle("reset_release_bomb");

    // Table of single held inputs, each held 8 cycles from idle.
    for (int i = 0; i < 18; i++) begin
      n = cyc;
      drive(vecs[i].btn, vecs[i].ja);
      if (vecs[i].am || vecs[i].ab || vecs[i].bm || vecs[i].bb)
        expect_ev(n + LAT, vecs[i].am, vecs[i].ad, vecs[i].ab, vecs[i].bm, vecs[i].bd, vecs[i].bb);
      ticks(8);
      release_and_settle($sformatf("vec%0d", i));
    end

    // Bomb held 40 cycles: one pulse only.
    n = cyc;
    drive(5'b00001, 8'h00);
    expect_ev(n + LAT, 1'b0, 2'b00, 1'b1, 1'b0, 2'b00, 1'b0);
    ticks(40);
    release_and_settle("bomb_hold");

    // Up button bouncing every 2 cycles, then steady.
    n = cyc;
    drive(5'b10000, 8'h00); ticks(2);
    drive(5'b00000, 8'h00); ticks(2);
    drive(5'b10000, 8'h00); ticks(2);
    drive(5'b00000, 8'h00); ticks(2);
    drive(5'b10000, 8'h00);
    expect_ev(n + 8 + LAT, 1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0);
    ticks(8);
    release_and_settle("bounce_up");

    // Right held 30 cycles: first pulse, delay 10, then period 5.
    n = cyc;
    drive(5'b00010, 8'h00);
    expect_ev(n + LAT,      1'b1, 2'b11, 1'b0, 1'b0, 2'b00, 1'b0);
    expect_ev(n + LAT + 10, 1'b1, 2'b11, 1'b0, 1'b0, 2'b00, 1'b0);
    expect_ev(n + LAT + 15, 1'b1, 2'b11, 1'b0, 1'b0, 2'b00, 1'b0);
    expect_ev(n + LAT + 20, 1'b1, 2'b11, 1'b0, 1'b0, 2'b00, 1'b0);
    expect_ev(n + LAT + 25, 1'b1, 2'b11, 1'b0, 1'b0, 2'b00, 1'b0);
    ticks(30);
    release_and_settle("repeat_right");
    checks++;
    if (a_dir != 2'b11) begin
      errors++;
      $display("FAIL a_dir_hold got=%b want=11", a_dir);
    end

    // Player B: pad idle, Up, then Left while held; change reloads the delay.
    n = cyc;
    drive(5'b0, 8'h10); ticks(4);
    drive(5'b0, 8'h30);
    expect_ev(n + 4 + LAT, 1'b0, 2'b00, 1'b0, 1'b1, 2'b00, 1'b0);
    ticks(8);
    drive(5'b0, 8'h70);
    expect_ev(n + 12 + LAT,      1'b0, 2'b00, 1'b0, 1'b1, 2'b10, 1'b0);
    expect_ev(n + 12 + LAT + 10, 1'b0, 2'b00, 1'b0, 1'b1, 2'b10, 1'b0);
    ticks(14);
    release_and_settle("b_dir_change");

    // Player B: Right -> Bomb -> Down.
    n = cyc;
    drive(5'b0, 8'h90);
    expect_ev(n + LAT, 1'b0, 2'b00, 1'b0, 1'b1, 2'b11, 1'b0);
    ticks(8);
    drive(5'b0, 8'hB0);
    expect_ev(n + 8 + LAT, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 1'b1);
    ticks(8);
    drive(5'b0, 8'h50);
    expect_ev(n + 16 + LAT, 1'b0, 2'b00, 1'b0, 1'b1, 2'b01, 1'b0);
    ticks(10);
    release_and_settle("b_dir_bomb_dir");

    // Reset in the middle of a hold: fresh first pulse after release.
    n = cyc;
    drive(5'b00100, 8'h00);
    expect_ev(n + LAT, 1'b1, 2'b10, 1'b0, 1'b0, 2'b00, 1'b0);
    ticks(12);
    rst = 1'b0;
    ticks(3);
    rst = 1'b1;
    n = cyc;
    expect_ev(n + LAT, 1'b1, 2'b10, 1'b0, 1'b0, 2'b00, 1'b0);
    ticks(10);
    release_and_settle("reset_mid_hold");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
